control_ingreso_teclas: RTL and testbench
=========================================

// Module: control_ingreso_teclas
// PURPOSE
//  Entry-control FSM directly upstream of almacenamiento_datos. Takes debounced keypad codes,
//  classifies digit/command keys, and issues the one-cycle tecla_pre/cargar_numero1/cargar_numero2/
//  reset_datos strobes that store two NUM_DIGITOS-digit operands. Signals when both operands are
//  complete so the arithmetic/display stage can proceed.
// PARAMETERS
//  NUM_DIGITOS  3      max digits accepted per operand
//  COD_SIG      4'hA   key: close operand 1, start operand 2
//  COD_FIN      4'hB   key: close operand 2, operands ready
//  COD_BORRAR   4'hC   key: clear everything, back to operand 1
// PORTS
//  clk              in   1   system clock
//  rst              in   1   asynchronous, active-high reset
//  tecla_codigo     in   4   debounced key code (0-9 digits, A-F commands)
//  tecla_valida     in   1   level, high while a debounced key is held
//  tecla_pre        out  4   registered code of last accepted digit
//  cargar_numero1   out  1   1-cycle pulse: store tecla_pre as next digit of operand 1
//  cargar_numero2   out  1   1-cycle pulse: store tecla_pre as next digit of operand 2
//  reset_datos      out  1   1-cycle pulse: clear both stored operands
//  cuenta_digitos   out  CW  digits entered in current operand, CW=$clog2(NUM_DIGITOS+1)
//  datos_listos     out  1   level, high while in LISTO
//  digito_descartado out 1   1-cycle pulse: digit key ignored (operand full / LISTO)
// BEHAVIOUR
//  - Reset: all outputs 0, state ESPERA_N1, cuenta_digitos=0; key-edge history register = 1,
//    so a key held through reset release is NOT accepted until released and pressed again.
//  - Accept event = rising edge of tecla_valida (sampled in cycle t); tecla_codigo sampled same cycle.
//  - All outputs registered; strobes appear in cycle t+1, exactly one cycle wide. One key -> at most
//    one strobe. tecla_pre updates only on accepted digits; holds value otherwise.
//  - States: ESPERA_N1, ESPERA_N2, LISTO.
//    ESPERA_N1: digit & cuenta<NUM_DIGITOS -> tecla_pre=code, cargar_numero1, cuenta++.
//               digit & cuenta==NUM_DIGITOS -> digito_descartado, no load.
//               COD_SIG & cuenta>0 -> ESPERA_N2, cuenta=0. COD_SIG & cuenta==0 -> ignored.
//    ESPERA_N2: same digit rules with cargar_numero2. COD_FIN & cuenta>0 -> LISTO, cuenta held.
//               COD_FIN & cuenta==0 -> ignored. COD_SIG ignored.
//    LISTO:     datos_listos=1; digit -> digito_descartado; SIG/FIN ignored.
//    Any state: COD_BORRAR -> reset_datos pulse, cuenta=0, ESPERA_N1, datos_listos=0 in t+1.
//  - Codes D,E,F and unlisted commands: ignored, no strobe.
//  - cargar_numero1, cargar_numero2, reset_datos never high in the same cycle.
//  - rst mid-entry: immediate return to reset values; no pending strobe survives.
//  - cuenta_digitos saturates at NUM_DIGITOS, never wraps.
// STRUCTURE
//  - pkg_teclado: typedef enum logic [1:0] {ESPERA_N1, ESPERA_N2, LISTO} estado_ingreso_t;
//    key-code constants COD_SIG/COD_FIN/COD_BORRAR defaults; helper function es_digito(code).
//  - Sub-module detector_flanco (1-bit rising-edge detector, reset value parameterised, here 1).
//  - Top: state register, digit counter, registered output strobes.
// TESTING
//  1 Press 5,3,6 (edges 4 cycles apart) -> three cargar_numero1 pulses, tecla_pre 5,3,6, cuenta 1,2,3.
//  2 4th digit 7 in ESPERA_N1 -> digito_descartado pulse, no cargar_numero1, tecla_pre stays 6.
//  3 A, then 9,1,8, B -> ESPERA_N2, three cargar_numero2 pulses, datos_listos=1 after B.
//  4 A with zero digits, B with zero digits -> no state change, no strobes.
//  5 C in ESPERA_N2 and in LISTO -> single reset_datos pulse, state ESPERA_N1, cuenta 0.
//  6 tecla_valida held high across rst release -> no strobe until release+repress; rst mid-entry
//    -> outputs 0 next edge, entry restarts in ESPERA_N1.

Source files
------------

// File: rtl/control_ingreso_teclas_pkg.sv
// Shared types and key-code constants for the keypad entry path.
// Consumers import pkg_teclado::* to get the state type and the digit classifier.
package pkg_teclado;

  typedef enum logic [1:0] {
    ESPERA_N1 = 2'd0,
    ESPERA_N2 = 2'd1,
    LISTO     = 2'd2
  } estado_ingreso_t;

  localparam logic [3:0] COD_SIG_DEF    = 4'hA;
  localparam logic [3:0] COD_FIN_DEF    = 4'hB;
  localparam logic [3:0] COD_BORRAR_DEF = 4'hC;
  localparam logic [3:0] COD_MAX_DIGITO = 4'h9;

  function automatic logic es_digito(input logic [3:0] codigo);
    return (codigo <= COD_MAX_DIGITO);
  endfunction

endpackage

// File: rtl/control_ingreso_teclas_detector_flanco.sv
// One-bit rising-edge detector. The history flop resets to RST_VAL, so a level that is
// already high when reset is released does not count as an edge.
module detector_flanco #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic senal,
  output logic flanco
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = senal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign flanco = senal & ~prev_q;

endmodule

// File: rtl/control_ingreso_teclas.sv
// Keypad entry controller: turns debounced key presses into load/clear strobes for two
// multi-digit operands and flags when both operands have been closed.
module control_ingreso_teclas
  import pkg_teclado::*;
#(
  parameter int         NUM_DIGITOS = 3,
  parameter logic [3:0] COD_SIG     = COD_SIG_DEF,
  parameter logic [3:0] COD_FIN     = COD_FIN_DEF,
  parameter logic [3:0] COD_BORRAR  = COD_BORRAR_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           tecla_codigo,
  input  logic                                 tecla_valida,
  output logic [3:0]                           tecla_pre,
  output logic                                 cargar_numero1,
  output logic                                 cargar_numero2,
  output logic                                 reset_datos,
  output logic [$clog2(NUM_DIGITOS+1)-1:0]     cuenta_digitos,
  output logic                                 datos_listos,
  output logic                                 digito_descartado
);

  localparam int            CW         = $clog2(NUM_DIGITOS + 1);
  localparam logic [CW-1:0] MAX_CUENTA = CW'(NUM_DIGITOS);
  localparam logic [CW-1:0] CUENTA_0   = {CW{1'b0}};

  logic            flanco_s;
  estado_ingreso_t estado_d,  estado_q;
  logic [CW-1:0]   cuenta_d,  cuenta_q;
  logic [3:0]      tecla_pre_d, tecla_pre_q;
  logic            cargar1_d, cargar1_q;
  logic            cargar2_d, cargar2_q;
  logic            reset_datos_d, reset_datos_q;
  logic            listo_d, listo_q;
  logic            descartado_d, descartado_q;

  detector_flanco #(.RST_VAL(1'b1)) u_flanco (
    .clk    (clk),
    .rst    (rst),
    .senal  (tecla_valida),
    .flanco (flanco_s)
  );

  always_comb begin
    estado_d      = estado_q;
    cuenta_d      = cuenta_q;
    tecla_pre_d   = tecla_pre_q;
    cargar1_d     = 1'b0;
    cargar2_d     = 1'b0;
    reset_datos_d = 1'b0;
    descartado_d  = 1'b0;
    if (flanco_s) begin
      // Clear wins from any state, so it is decoded ahead of the per-state rules.
      if (tecla_codigo == COD_BORRAR) begin
        reset_datos_d = 1'b1;
        cuenta_d      = CUENTA_0;
        estado_d      = ESPERA_N1;
      end else begin
        case (estado_q)
          ESPERA_N1: begin
            if (es_digito(tecla_codigo)) begin
              if (cuenta_q < MAX_CUENTA) begin
                tecla_pre_d = tecla_codigo;
                cargar1_d   = 1'b1;
                cuenta_d    = cuenta_q + CW'(1);
              end else begin
                descartado_d = 1'b1;
              end
            end else if ((tecla_codigo == COD_SIG) && (cuenta_q != CUENTA_0)) begin
              estado_d = ESPERA_N2;
              cuenta_d = CUENTA_0;
            end else begin
              estado_d = estado_q;
            end
          end
          ESPERA_N2: begin
            if (es_digito(tecla_codigo)) begin
              if (cuenta_q < MAX_CUENTA) begin
                tecla_pre_d = tecla_codigo;
                cargar2_d   = 1'b1;
                cuenta_d    = cuenta_q + CW'(1);
              end else begin
                descartado_d = 1'b1;
              end
            end else if ((tecla_codigo == COD_FIN) && (cuenta_q != CUENTA_0)) begin
              estado_d = LISTO;
            end else begin
              estado_d = estado_q;
            end
          end
          LISTO: begin
            if (es_digito(tecla_codigo)) begin
              descartado_d = 1'b1;
            end else begin
              estado_d = estado_q;
            end
          end
          default: begin
            estado_d = ESPERA_N1;
            cuenta_d = CUENTA_0;
          end
        endcase
      end
    end else begin
      estado_d = estado_q;
    end
    listo_d = (estado_d == LISTO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q      <= ESPERA_N1;
      cuenta_q      <= CUENTA_0;
      tecla_pre_q   <= 4'h0;
      cargar1_q     <= 1'b0;
      cargar2_q     <= 1'b0;
      reset_datos_q <= 1'b0;
      listo_q       <= 1'b0;
      descartado_q  <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cuenta_q      <= cuenta_d;
      tecla_pre_q   <= tecla_pre_d;
      cargar1_q     <= cargar1_d;
      cargar2_q     <= cargar2_d;
      reset_datos_q <= reset_datos_d;
      listo_q       <= listo_d;
      descartado_q  <= descartado_d;
    end
  end

  assign tecla_pre         = tecla_pre_q;
  assign cargar_numero1    = cargar1_q;
  assign cargar_numero2    = cargar2_q;
  assign reset_datos       = reset_datos_q;
  assign cuenta_digitos    = cuenta_q;
  assign datos_listos      = listo_q;
  assign digito_descartado = descartado_q;

endmodule

// File: tb/tb_control_ingreso_teclas.sv
// Bench for control_ingreso_teclas: directed key sequences followed by random presses,
// every cycle compared against an operand-queue reference model.
module tb_control_ingreso_teclas;

  localparam int NDIG = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tecla_codigo;
  logic       tecla_valida;
  logic [3:0] tecla_pre;
  logic       cargar_numero1, cargar_numero2, reset_datos;
  logic [1:0] cuenta_digitos;
  logic       datos_listos, digito_descartado;

  control_ingreso_teclas dut (
    .clk               (clk),
    .rst               (rst),
    .tecla_codigo      (tecla_codigo),
    .tecla_valida      (tecla_valida),
    .tecla_pre         (tecla_pre),
    .cargar_numero1    (cargar_numero1),
    .cargar_numero2    (cargar_numero2),
    .reset_datos       (reset_datos),
    .cuenta_digitos    (cuenta_digitos),
    .datos_listos      (datos_listos),
    .digito_descartado (digito_descartado)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: operands as digit lists, phase 0/1/2 = entering op1 / op2 / done.
  int         op1[$];
  int         op2[$];
  int         fase;
  logic       prev_v;
  logic [3:0] e_pre;
  logic       e_c1, e_c2, e_rd, e_desc;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    op1.delete();
    op2.delete();
    fase   = 0;
    prev_v = 1'b1;
    e_pre  = 4'h0;
    e_c1 = 1'b0; e_c2 = 1'b0; e_rd = 1'b0; e_desc = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    e_c1 = 1'b0; e_c2 = 1'b0; e_rd = 1'b0; e_desc = 1'b0;
    if (v && !prev_v) begin
      if (c == 4'hC) begin
        op1.delete();
        op2.delete();
        fase = 0;
        e_rd = 1'b1;
      end else if (c <= 4'd9) begin
        if (fase == 0 && op1.size() < NDIG) begin
          op1.push_back(int'(c)); e_pre = c; e_c1 = 1'b1;
        end else if (fase == 1 && op2.size() < NDIG) begin
          op2.push_back(int'(c)); e_pre = c; e_c2 = 1'b1;
        end else begin
          e_desc = 1'b1;
        end
      end else if (c == 4'hA && fase == 0 && op1.size() > 0) begin
        fase = 1;
      end else if (c == 4'hB && fase == 1 && op2.size() > 0) begin
        fase = 2;
      end
    end
    prev_v = v;
  endtask

  task automatic compare_all(input string tag);
    int exp_cnt;
    exp_cnt = (fase == 0) ? op1.size() : op2.size();
    chk_eq({tag, ".tecla_pre"}, 32'(tecla_pre), 32'(e_pre));
    chk_eq({tag, ".strobes"},
           32'({cargar_numero1, cargar_numero2, reset_datos, digito_descartado}),
           32'({e_c1, e_c2, e_rd, e_desc}));
    chk_eq({tag, ".cuenta"}, 32'(cuenta_digitos), 32'(exp_cnt));
    chk_eq({tag, ".listo"}, 32'(datos_listos), 32'(fase == 2));
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(tecla_valida, tecla_codigo);
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap, input string tag);
    tecla_codigo = c;
    tecla_valida = 1'b1;
    repeat (hold) tick(tag);
    tecla_valida = 1'b0;
    tecla_codigo = 4'($urandom_range(0, 15));
    repeat (gap) tick(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
  endtask

  initial begin
    rst          = 1'b1;
    tecla_valida = 1'b0;
    tecla_codigo = 4'h0;
    @(negedge clk);
    model_reset();
    compare_all("reset");
    tick("reset");
    rst = 1'b0;
    tick("idle");

    // Three digits, then a rejected fourth
    press(4'd5, 2, 2, "d5");
    press(4'd3, 2, 2, "d3");
    press(4'd6, 2, 2, "d6");
    press(4'd7, 2, 2, "full1");
    // Operand 2 and finish
    press(4'hA, 1, 2, "sig");
    press(4'hB, 1, 2, "fin_empty");
    press(4'hA, 1, 2, "sig_in_n2");
    press(4'd9, 1, 1, "d9");
    press(4'd1, 3, 1, "d1");
    press(4'd8, 1, 3, "d8");
    press(4'd4, 1, 1, "full2");
    press(4'hB, 1, 2, "fin");
    press(4'd2, 1, 2, "digit_listo");
    press(4'hA, 1, 1, "sig_listo");
    press(4'hE, 1, 1, "cod_e");
    press(4'hC, 1, 2, "borrar_listo");
    // Empty operand 1: SIG and FIN ignored
    press(4'hA, 1, 1, "sig_empty");
    press(4'hB, 1, 1, "fin_n1");
    press(4'd0, 1, 1, "d0");
    press(4'hA, 1, 1, "sig2");
    press(4'd3, 1, 1, "d3b");
    press(4'hC, 1, 2, "borrar_n2");

    // Key held across reset release must not be accepted
    tecla_codigo = 4'd4;
    tecla_valida = 1'b1;
    async_reset("rst_held");
    tick("rst_held");
    rst = 1'b0;
    repeat (3) tick("held_after_rst");
    tecla_valida = 1'b0;
    tick("release");
    press(4'd4, 1, 1, "repress");
    // Reset in the middle of an entry
    tecla_codigo = 4'd2;
    tecla_valida = 1'b1;
    tick("mid_entry");
    async_reset("rst_mid");
    tick("rst_mid");
    tecla_valida = 1'b0;
    rst = 1'b0;
    tick("restart");
    press(4'd8, 1, 1, "restart_d8");

    // Random keys, holds and gaps with occasional reset
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 99));
      if      (r < 55) c = 4'($urandom_range(0, 9));
      else if (r < 70) c = 4'hA;
      else if (r < 82) c = 4'hB;
      else if (r < 90) c = 4'hC;
      else             c = 4'($urandom_range(13, 15));
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
        tick("rnd_rst");
        rst = 1'b0;
      end
      press(c, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
